// File: rtl/cntr_seq_ctrl_pkg.sv
// Shared encodings for the counter sequencer and its prescaler.
package cntr_seq_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;
endpackage

// File: rtl/cntr_seq_presc.sv
// Prescaler: emits a tick every presc_q+1 enabled cycles; clr restarts the phase.
module cntr_seq_presc #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc_q,
  output logic               tick
);
  logic [PRESC_W-1:0] presc_cnt;

  assign tick = en && (presc_cnt == presc_q);

  // A disabled cycle (stop or not running) freezes the phase.
  always_ff @(posedge clk) begin
    if (rst)      presc_cnt <= '0;
    else if (clr) presc_cnt <= '0;
    else if (en)  presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
  end
endmodule

// File: rtl/cntr_seq_ctrl.sv
// Start/stop sequencer driving a prescaled up-counter with one-shot and auto-reload modes.
module cntr_seq_ctrl
  import cntr_seq_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [WIDTH-1:0]   limit,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic               wrap
);
  state_t             state, state_nx;
  logic [WIDTH-1:0]   count_nx, limit_q;
  logic [PRESC_W-1:0] presc_q;
  logic               mode_q, wrap_nx, launch, en;

  assign busy = (state == ST_RUN);
  assign en   = busy && !stop;

  cntr_seq_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch),
    .en      (en),
    .presc_q (presc_q),
    .tick    (tick)
  );

  always_comb begin
    state_nx = state;
    count_nx = count;
    wrap_nx  = 1'b0;
    launch   = 1'b0;
    case (state)
      ST_IDLE: launch = start;
      ST_RUN: begin
        if (stop) begin
          state_nx = ST_IDLE;
        end else if (tick) begin
          if (count != limit_q) begin
            count_nx = count + 1'b1;
          end else if (mode_q == MODE_RELOAD) begin
            count_nx = '0;
            wrap_nx  = 1'b1;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        launch   = start;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // A restart from IDLE or DONE begins a fresh run from zero.
    if (launch) begin
      state_nx = ST_RUN;
      count_nx = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= '0;
      limit_q <= '0;
      presc_q <= '0;
      mode_q  <= MODE_ONESHOT;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      done  <= (state_nx == ST_DONE);
      wrap  <= wrap_nx;
      if (launch) begin
        limit_q <= limit;
        presc_q <= presc;
        mode_q  <= mode;
      end
    end
  end
endmodule

// File: tb/tb_cntr_seq_ctrl.sv
// Randomized and directed bench for cntr_seq_ctrl against an elapsed-time reference model.
module tb_cntr_seq_ctrl;
  localparam int WIDTH   = 4;
  localparam int PRESC_W = 8;

  logic               clk = 1'b0;
  logic               rst, start, stop, mode;
  logic [WIDTH-1:0]   limit;
  logic [PRESC_W-1:0] presc;
  logic               tick, busy, done, wrap;
  logic [WIDTH-1:0]   count;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: phase 0 idle, 1 running, 2 done-cycle.
  // While running, outputs follow from t = cycles elapsed since the start edge.
  int ph = 0, t = 0, lim_m = 0, pre_m = 0, mod_m = 0, hold_m = 0;
  bit done_m = 0, wrap_m = 0;

  cntr_seq_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .limit(limit), .presc(presc), .tick(tick), .count(count),
    .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int exp_count();
    int ticks;
    if (ph != 1) return hold_m;
    ticks = t / (pre_m + 1);
    return mod_m ? ticks % (lim_m + 1) : ticks;
  endfunction

  function automatic int exp_tick();
    return (ph == 1 && (t % (pre_m + 1)) == pre_m && !stop) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d want %0d", tag, $time, obs, exp);
  endtask

  task automatic model_edge();
    int c;
    int tk;
    c  = exp_count();
    tk = exp_tick();
    if (rst) begin
      ph = 0; hold_m = 0; done_m = 0; wrap_m = 0; t = 0;
    end else if (ph == 1) begin
      wrap_m = 0;
      if (stop) begin
        hold_m = c; ph = 0;
      end else if (tk == 1 && mod_m == 0 && c == lim_m) begin
        hold_m = lim_m; ph = 2; done_m = 1;
      end else begin
        if (tk == 1 && mod_m == 1 && c == lim_m) wrap_m = 1;
        t++;
      end
    end else begin
      done_m = 0; wrap_m = 0;
      if (start) begin
        lim_m = int'(limit); pre_m = int'(presc); mod_m = int'(mode);
        t = 0; ph = 1;
      end else begin
        ph = 0;
      end
    end
  endtask

  // Compare mid-cycle, then advance one edge; inputs are changed by the caller afterwards.
  task automatic step();
    @(negedge clk);
    if (chk_en) begin
      chk("busy",  int'(busy),  ph == 1 ? 1 : 0);
      chk("done",  int'(done),  int'(done_m));
      chk("wrap",  int'(wrap),  int'(wrap_m));
      chk("tick",  int'(tick),  exp_tick());
      chk("count", int'(count), exp_count());
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic launch(input bit m, input int l, input int p);
    start = 1'b1; mode = m; limit = WIDTH'(l); presc = PRESC_W'(p);
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = '0; presc = '0;
    @(posedge clk); #1;
    model_edge();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // One-shot limit=3, presc=0.
    launch(1'b0, 3, 0);
    repeat (6) step();

    // Auto-reload limit=2, presc=1, then reset held two cycles mid-run.
    launch(1'b1, 2, 1);
    repeat (15) step();
    rst = 1'b1; step(); step(); rst = 1'b0;
    step();

    // One-shot limit=15, presc=3, stopped at count 5, then restarted.
    launch(1'b0, 15, 3);
    repeat (20) step();
    chk("stop_at", int'(count), 5);
    stop = 1'b1; step(); stop = 1'b0;
    repeat (3) step();
    launch(1'b0, 15, 0);
    repeat (18) step();

    // limit=0 boundaries.
    launch(1'b0, 0, 0);
    repeat (3) step();
    launch(1'b1, 0, 2);
    repeat (10) step();
    stop = 1'b1; step(); stop = 1'b0;

    // Inputs churn and start pulses during a run must not disturb it.
    launch(1'b0, 5, 1);
    for (int i = 0; i < 16; i++) begin
      start = 1'($urandom); mode = 1'($urandom);
      limit = WIDTH'($urandom); presc = PRESC_W'($urandom);
      step();
    end
    start = 1'b0;
    repeat (2) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      mode  = 1'($urandom);
      limit = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
      presc = PRESC_W'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
